// File: rtl/ray_dispatcher_pkg.sv
// Shared raycaster definitions: dispatcher state encoding, frame geometry
// defaults and the small helpers the pipeline stages have in common.
package ray_dispatcher_pkg;

    localparam int SCREEN_WIDTH_DEF = 320;
    localparam int PW_DEF           = 16;
    localparam int HCOUNT_W         = 9;
    localparam int POSE_WORDS       = 6;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_POSE = 2'd1,
        ISSUE     = 2'd2
    } disp_state_t;

    // The overrun counter sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ray_dispatcher.sv
// Freezes the controller pose at frame start and issues one ray column per
// accepted valid/ready handshake toward ray_calculations.
module ray_dispatcher
    import ray_dispatcher_pkg::*;
#(
    parameter int SCREEN_WIDTH = SCREEN_WIDTH_DEF,
    parameter int PW           = PW_DEF
) (
    input  logic                pixel_clk_in,
    input  logic                rst_in,
    input  logic                frame_start_in,
    input  logic                pose_valid_in,
    input  logic [PW-1:0]       posX_in,
    input  logic [PW-1:0]       posY_in,
    input  logic [PW-1:0]       dirX_in,
    input  logic [PW-1:0]       dirY_in,
    input  logic [PW-1:0]       planeX_in,
    input  logic [PW-1:0]       planeY_in,
    output logic [PW-1:0]       posX_out,
    output logic [PW-1:0]       posY_out,
    output logic [PW-1:0]       dirX_out,
    output logic [PW-1:0]       dirY_out,
    output logic [PW-1:0]       planeX_out,
    output logic [PW-1:0]       planeY_out,
    output logic [HCOUNT_W-1:0] hcount_out,
    output logic                valid_out,
    input  logic                ready_in,
    output logic                last_out,
    output logic                busy_out,
    output logic                done_out,
    output logic [7:0]          overrun_out
);

    localparam logic [HCOUNT_W-1:0] LAST_COL = HCOUNT_W'(SCREEN_WIDTH - 1);

    disp_state_t         r_state;
    logic [HCOUNT_W-1:0] r_hcount;
    logic                r_done;
    logic [7:0]          r_overrun;
    logic [PW-1:0]       r_pose    [POSE_WORDS];
    logic [PW-1:0]       w_pose_in [POSE_WORDS];
    logic                w_latch;
    logic                w_last_col;

    assign w_pose_in[0] = posX_in;
    assign w_pose_in[1] = posY_in;
    assign w_pose_in[2] = dirX_in;
    assign w_pose_in[3] = dirY_in;
    assign w_pose_in[4] = planeX_in;
    assign w_pose_in[5] = planeY_in;

    assign w_last_col = (r_hcount == LAST_COL);
    assign w_latch    = pose_valid_in &&
                        (((r_state == IDLE) && frame_start_in) || (r_state == WAIT_POSE));

    // Pose snapshot bank: only a latch event may change it.
    generate
        for (genvar gi = 0; gi < POSE_WORDS; gi++) begin : g_pose
            always_ff @(posedge pixel_clk_in) begin
                if (!rst_in) begin
                    r_pose[gi] <= '0;
                end else if (w_latch) begin
                    r_pose[gi] <= w_pose_in[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge pixel_clk_in) begin
        if (!rst_in) begin
            r_state   <= IDLE;
            r_hcount  <= '0;
            r_done    <= 1'b0;
            r_overrun <= '0;
        end else begin
            r_done <= 1'b0;
            // Requests arriving while a frame is pending or running are dropped.
            if (frame_start_in && (r_state != IDLE)) begin
                r_overrun <= sat_inc8(r_overrun);
            end
            case (r_state)
                IDLE: begin
                    if (frame_start_in) begin
                        if (pose_valid_in) begin
                            r_hcount <= '0;
                            r_state  <= ISSUE;
                        end else begin
                            r_state  <= WAIT_POSE;
                        end
                    end
                end
                WAIT_POSE: begin
                    if (pose_valid_in) begin
                        r_hcount <= '0;
                        r_state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (ready_in) begin
                        if (w_last_col) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_hcount <= r_hcount + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // All handshake outputs decode registered state only, so ready_in never
    // reaches valid_out combinationally.
    assign valid_out   = (r_state == ISSUE);
    assign busy_out    = (r_state != IDLE);
    assign last_out    = valid_out && w_last_col;
    assign done_out    = r_done;
    assign hcount_out  = r_hcount;
    assign overrun_out = r_overrun;
    assign posX_out    = r_pose[0];
    assign posY_out    = r_pose[1];
    assign dirX_out    = r_pose[2];
    assign dirY_out    = r_pose[3];
    assign planeX_out  = r_pose[4];
    assign planeY_out  = r_pose[5];

endmodule

// File: tb/tb_ray_dispatcher.sv
// Self-checking bench for ray_dispatcher: constant vector table, directed
// frame scenarios and randomized traffic against a frame-level reference model.
module tb_ray_dispatcher;
    import ray_dispatcher_pkg::*;

    localparam int W   = 320;
    localparam int PWT = 16;

    logic           clk = 1'b0;
    logic           rst_in = 1'b0;
    logic           frame_start_in = 1'b0;
    logic           pose_valid_in = 1'b0;
    logic           ready_in = 1'b0;
    logic [PWT-1:0] posX_in = '0, posY_in = '0, dirX_in = '0, dirY_in = '0;
    logic [PWT-1:0] planeX_in = '0, planeY_in = '0;
    logic [PWT-1:0] posX_out, posY_out, dirX_out, dirY_out, planeX_out, planeY_out;
    logic [8:0]     hcount_out;
    logic           valid_out, last_out, busy_out, done_out;
    logic [7:0]     overrun_out;

    typedef logic [5:0][PWT-1:0] pose_t;

    always #5 clk = ~clk;

    ray_dispatcher #(.SCREEN_WIDTH(W), .PW(PWT)) dut (
        .pixel_clk_in   (clk),
        .rst_in         (rst_in),
        .frame_start_in (frame_start_in),
        .pose_valid_in  (pose_valid_in),
        .posX_in        (posX_in),
        .posY_in        (posY_in),
        .dirX_in        (dirX_in),
        .dirY_in        (dirY_in),
        .planeX_in      (planeX_in),
        .planeY_in      (planeY_in),
        .posX_out       (posX_out),
        .posY_out       (posY_out),
        .dirX_out       (dirX_out),
        .dirY_out       (dirY_out),
        .planeX_out     (planeX_out),
        .planeY_out     (planeY_out),
        .hcount_out     (hcount_out),
        .valid_out      (valid_out),
        .ready_in       (ready_in),
        .last_out       (last_out),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .overrun_out    (overrun_out)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a frame is either waiting for a pose, issuing columns, or absent.
    bit    m_waiting, m_issuing, m_done;
    int    m_col, m_ovr;
    pose_t m_pose;

    int xfer_q[$];
    int n_last, n_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic pose_t rand_pose();
        pose_t p;
        for (int i = 0; i < 6; i++) p[i] = PWT'($urandom);
        return p;
    endfunction

    task automatic step(input bit r, input bit fs, input bit pv, input bit rdy, input pose_t p);
        rst_in = r; frame_start_in = fs; pose_valid_in = pv; ready_in = rdy;
        posX_in = p[0]; posY_in = p[1]; dirX_in = p[2];
        dirY_in = p[3]; planeX_in = p[4]; planeY_in = p[5];
        if (r && (valid_out === 1'b1) && rdy) xfer_q.push_back(int'(hcount_out));
        @(posedge clk);
        if (!r) begin
            m_waiting = 0; m_issuing = 0; m_done = 0; m_col = 0; m_ovr = 0; m_pose = '0;
        end else begin
            m_done = 0;
            if (fs && (m_waiting || m_issuing)) m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
            if (m_issuing) begin
                if (rdy) begin
                    if (m_col == W - 1) begin m_issuing = 0; m_done = 1; end
                    else m_col = m_col + 1;
                end
            end else if ((m_waiting || fs) && pv) begin
                m_pose = p; m_col = 0; m_waiting = 0; m_issuing = 1;
            end else if (fs) begin
                m_waiting = 1;
            end
        end
        #1;
        chk("valid", valid_out, m_issuing);
        chk("hcount", hcount_out, m_col);
        chk("last", last_out, m_issuing && (m_col == W - 1));
        chk("busy", busy_out, m_issuing || m_waiting);
        chk("done", done_out, m_done);
        chk("overrun", overrun_out, m_ovr);
        chk("pose", {posX_out, posY_out, dirX_out, dirY_out, planeX_out, planeY_out},
            {m_pose[0], m_pose[1], m_pose[2], m_pose[3], m_pose[4], m_pose[5]});
        if (last_out) n_last++;
        if (done_out) n_done++;
    endtask

    // Drives random ready (pct% high) until the model says the frame is over.
    task automatic run_frame(input int pct);
        int cyc = 0;
        while ((m_waiting || m_issuing) && cyc < 4000) begin
            step(1, 0, 1, ($urandom_range(0, 99) < pct), rand_pose());
            cyc++;
        end
        chk("frame_timeout", (m_waiting || m_issuing), 0);
    endtask

    task automatic check_sb(input string tag);
        int bad = 0;
        chk({tag, "_xfer_count"}, xfer_q.size(), W);
        foreach (xfer_q[i]) if (xfer_q[i] != i) bad++;
        chk({tag, "_xfer_order"}, bad, 0);
    endtask

    typedef struct {
        bit r, fs, pv, rdy;
        logic [15:0] px;
        bit e_valid;
        int e_hc;
        bit e_last, e_busy, e_done;
        int e_ovr;
        logic [15:0] e_px;
    } vec_t;

    vec_t tbl[10];

    initial begin
        pose_t p;
        int ovr0;

        tbl[0] = '{0,1,1,1,16'h1111, 0,0,0,0,0,0,16'h0000};
        tbl[1] = '{1,0,0,0,16'h1111, 0,0,0,0,0,0,16'h0000};
        tbl[2] = '{1,1,0,1,16'h2222, 0,0,0,1,0,0,16'h0000};
        tbl[3] = '{1,0,0,1,16'h3333, 0,0,0,1,0,0,16'h0000};
        tbl[4] = '{1,1,0,0,16'h3333, 0,0,0,1,0,1,16'h0000};
        tbl[5] = '{1,0,1,0,16'h4444, 1,0,0,1,0,1,16'h4444};
        tbl[6] = '{1,0,1,0,16'h5555, 1,0,0,1,0,1,16'h4444};
        tbl[7] = '{1,0,1,1,16'h6666, 1,1,0,1,0,1,16'h4444};
        tbl[8] = '{1,1,1,1,16'h7777, 1,2,0,1,0,2,16'h4444};
        tbl[9] = '{1,0,1,0,16'h8888, 1,2,0,1,0,2,16'h4444};

        for (int v = 0; v < 10; v++) begin
            for (int i = 0; i < 6; i++) p[i] = tbl[v].px + 16'(i);
            step(tbl[v].r, tbl[v].fs, tbl[v].pv, tbl[v].rdy, p);
            chk("tbl_valid", valid_out, tbl[v].e_valid);
            chk("tbl_hcount", hcount_out, tbl[v].e_hc);
            chk("tbl_last", last_out, tbl[v].e_last);
            chk("tbl_busy", busy_out, tbl[v].e_busy);
            chk("tbl_done", done_out, tbl[v].e_done);
            chk("tbl_overrun", overrun_out, tbl[v].e_ovr);
            chk("tbl_posx", posX_out, tbl[v].e_px);
            $display("vec %0d: rst=%0b fs=%0b pv=%0b rdy=%0b -> valid=%0b hc=%0d busy=%0b ovr=%0d posX=%h",
                     v, tbl[v].r, tbl[v].fs, tbl[v].pv, tbl[v].rdy,
                     valid_out, hcount_out, busy_out, overrun_out, posX_out);
        end
        run_frame(100);
        $display("table frame finished, done pulses=%0d", n_done);

        // Full frame with ready held high.
        step(0, 0, 0, 0, rand_pose());
        step(1, 0, 0, 1, rand_pose());
        xfer_q.delete(); n_last = 0; n_done = 0;
        p = rand_pose(); p[0] = 16'h0340;
        step(1, 1, 1, 1, p);
        chk("f1_valid_rise", valid_out, 1);
        for (int c = 0; c < W; c++) begin
            step(1, 0, 1, 1, rand_pose());
            chk("f1_posx_frozen", posX_out, 16'h0340);
        end
        check_sb("f1");
        chk("f1_last_count", n_last, 1);
        chk("f1_done_count", n_done, 1);
        chk("f1_idle", busy_out, 0);
        $display("frame ready=1: %0d transfers, last=%0d done=%0d", xfer_q.size(), n_last, n_done);

        // Random 50% backpressure.
        xfer_q.delete();
        step(1, 1, 1, 0, rand_pose());
        run_frame(50);
        check_sb("f2");
        $display("frame ready=50%%: %0d transfers", xfer_q.size());

        // Frame request before the pose is valid.
        step(1, 1, 0, 1, rand_pose());
        for (int c = 0; c < 4; c++) begin
            step(1, 0, 0, 1, rand_pose());
            chk("wp_waiting", {busy_out, valid_out}, 2'b10);
        end
        p = rand_pose();
        step(1, 0, 1, 0, p);
        chk("wp_valid", valid_out, 1);
        chk("wp_posx", posX_out, p[0]);
        chk("wp_planey", planeY_out, p[5]);
        run_frame(70);
        $display("wait-pose frame: pose %h latched", p[0]);

        // Overruns during ISSUE and on the final transfer.
        step(0, 0, 0, 0, rand_pose());
        step(1, 1, 1, 1, rand_pose());
        begin
            int cyc = 0;
            while (m_issuing && cyc < 1000) begin
                step(1, (m_col == 10 || m_col == 100 || m_col == 200 || m_col == W - 1),
                     1, 1, rand_pose());
                cyc++;
            end
        end
        chk("ovr_count4", overrun_out, 4);
        chk("ovr_no_restart", busy_out, 0);
        step(1, 1, 1, 1, rand_pose());
        chk("ovr_restart", {valid_out, hcount_out}, {1'b1, 9'd0});
        run_frame(100);
        $display("overrun frame: overrun=%0d", overrun_out);

        // Reset mid-frame at column 150.
        step(1, 1, 1, 1, rand_pose());
        begin
            int cyc = 0;
            while (m_col != 150 && cyc < 1000) begin
                step(1, 0, 1, 1, rand_pose());
                cyc++;
            end
        end
        chk("mid_at150", hcount_out, 150);
        ovr0 = n_done;
        step(0, 0, 1, 1, rand_pose());
        chk("mid_rst_outs", {valid_out, last_out, busy_out, done_out, hcount_out, overrun_out, posX_out},
            '0);
        step(1, 0, 1, 1, rand_pose());
        chk("mid_no_done", n_done, ovr0);
        step(1, 1, 1, 1, rand_pose());
        chk("mid_restart", {valid_out, hcount_out}, {1'b1, 9'd0});
        run_frame(100);
        $display("mid-frame reset: restart ok");

        // Saturation of the overrun counter.
        step(0, 0, 0, 0, rand_pose());
        step(1, 1, 1, 0, rand_pose());
        for (int c = 0; c < 300; c++) step(1, 1, 1, 0, rand_pose());
        chk("ovr_sat", overrun_out, 255);
        $display("overrun saturation: overrun=%0d", overrun_out);

        // Randomized traffic.
        step(0, 0, 0, 0, rand_pose());
        for (int c = 0; c < 4000; c++) begin
            step(($urandom_range(0, 299) != 0), ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 9) < 7), $urandom_range(0, 1), rand_pose());
        end
        $display("random traffic: done pulses=%0d overrun=%0d", n_done, overrun_out);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ray_dispatcher.md
RAY_DISPATCHER -- requirements
Module: ray_dispatcher

Interface
REQ-001 Parameter SCREEN_WIDTH, default 320, gives the number of ray columns per frame.
REQ-002 Parameter PW, default 16, gives the pose word width.
REQ-003 pixel_clk_in  input  1  is the single clock; all logic is on its rising edge.
REQ-004 rst_in  input  1  is a synchronous, active-low reset.
REQ-005 frame_start_in  input  1  is a one-cycle request to cast a new frame (driven from the video new_frame pulse).
REQ-006 pose_valid_in  input  1  is high when the controller pose inputs are stable.
REQ-007 posX_in, posY_in, dirX_in, dirY_in, planeX_in, planeY_in  input  PW each  carry the live controller pose.
REQ-008 posX_out, posY_out, dirX_out, dirY_out, planeX_out, planeY_out  output  PW each  carry the frame-frozen pose snapshot.
REQ-009 hcount_out  output  9  is the column index.
REQ-010 valid_out  output  1  is the source valid toward ray_calculations.
REQ-011 ready_in  input  1  is the sink ready.
REQ-012 last_out  output  1  is high with column SCREEN_WIDTH-1.
REQ-013 busy_out  output  1  is high while not IDLE.
REQ-014 done_out  output  1  is a one-cycle pulse after the final column transfers.
REQ-015 overrun_out  output  8  is a saturating count of dropped frame requests.

Function
REQ-016 The FSM shall have exactly three states: IDLE, WAIT_POSE and ISSUE.
REQ-017 In IDLE, frame_start_in with pose_valid_in high shall latch all six pose inputs, set hcount to 0 and enter ISSUE.
REQ-018 In IDLE, frame_start_in with pose_valid_in low shall enter WAIT_POSE with no latch.
REQ-019 WAIT_POSE shall latch the pose, set hcount to 0 and enter ISSUE on the first cycle pose_valid_in is high.
REQ-020 valid_out shall be high exactly while in ISSUE, starting the cycle after the latch (1-cycle latency).
REQ-021 A transfer occurs when valid_out and ready_in are both high.
REQ-022 While valid_out is high and ready_in is low, hcount_out, last_out and all pose outputs shall hold stable.
REQ-023 On a transfer with hcount below SCREEN_WIDTH-1, hcount shall increment by 1 on the next cycle.
REQ-024 On a transfer with hcount equal to SCREEN_WIDTH-1, the FSM shall enter IDLE and pulse done_out on the next cycle; hcount shall never reach SCREEN_WIDTH.
REQ-025 last_out shall equal valid_out AND (hcount_out == SCREEN_WIDTH-1).
REQ-026 Pose outputs shall change only on a latch event and shall hold across IDLE.
REQ-027 frame_start_in while in WAIT_POSE or ISSUE shall be ignored for sequencing and shall increment overrun_out, saturating at 255.
REQ-028 frame_start_in in the same cycle as the final transfer shall be counted as an overrun, not started; the FSM still enters IDLE.
REQ-029 ready_in high while valid_out is low shall have no effect.
REQ-030 The block shall contain no combinational path from ready_in to valid_out.

Reset
REQ-031 While rst_in is low at a clock edge, the FSM shall be in IDLE.
REQ-032 While rst_in is low at a clock edge, hcount_out, valid_out, last_out, done_out, busy_out, overrun_out and all pose outputs shall be 0.
REQ-033 Reset asserted mid-ISSUE shall abort the frame with no done_out pulse.
REQ-034 frame_start_in in the same cycle as reset shall be discarded.

Structure
REQ-035 The state enum, SCREEN_WIDTH default and PW default shall live in the shared raycaster package for reuse by ray_calculations and dda.
REQ-036 The block shall be a single module with no sub-modules; the pose snapshot is a plain register bank inside it.
REQ-037 hcount_out shall be declared 9 bits wide to match hcount_in of ray_calculations.

Verification
REQ-038 Reset release, then frame_start with pose_valid=1, posX=0x0340, and ready held 1 -> valid rises 1 cycle later; hcount 0..319 on 320 consecutive cycles; last_out only at 319; done_out pulses once; posX_out=0x0340 throughout.
REQ-039 ready toggled by a random 50% pattern -> every column 0..319 transfers exactly once, in order, with outputs stable whenever ready is low.
REQ-040 frame_start with pose_valid=0, then pose_valid raised 5 cycles later -> FSM in WAIT_POSE for 5 cycles; the first valid carries the pose present on the raising cycle.
REQ-041 Three frame_start pulses during ISSUE, plus one on the final-transfer cycle -> overrun_out=4; no restart; the next frame_start after done starts normally.
REQ-042 rst_in low at hcount=150 -> next cycle all outputs are 0 with no done_out; a fresh frame restarts at hcount 0.
REQ-043 300 overrun pulses -> overrun_out saturates at 255.
